uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Transmit-side counterpart of the Arduino UART receive buffer: accepts bytes from FPGA logic over a valid/ready handshake, queues them in a FIFO, and serializes them as 8N1 UART frames onto a GPIO pin toward the Arduino.
- Sits between application logic (e.g. command/telemetry generator) and the physical TX pin.
- Decouples bursty byte producers from the slow baud-rate line.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be >= 2
- DEPTH, 16, FIFO depth in bytes; power of two, >= 2

Ports:
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  synchronous active-low reset
- data_in  input  8  byte to transmit
- valid_in  input  1  data_in is valid this cycle
- ready_out  output  1  FIFO can accept a byte this cycle
- uart_out  output  1  serial TX line, idles high
- busy  output  1  frame in progress or FIFO non-empty
- count  output  $clog2(DEPTH)+1  bytes currently queued, excluding the byte being shifted

Behaviour:
- Reset (rst_n low at a rising edge): FIFO emptied, count=0, FSM=IDLE, baud counter=0, uart_out=1, busy=0. ready_out=0 while rst_n is low and 1 from the first cycle after release. Reset mid-frame aborts the frame: uart_out returns high on the next edge, and all queued data is lost.
- Handshake: a byte is pushed at a rising edge where valid_in && ready_out. ready_out = !full, combinational from registered state. When the FIFO is full, no push occurs, even if a pop happens in the same cycle. Data presented while ready_out=0 is ignored and not stored. Producers may hold valid_in high across cycles, and each accepting edge stores one byte.
- FIFO: circular buffer, with read and write pointers wrapping modulo DEPTH. Simultaneous push and pop leave count unchanged. A push into an empty FIFO becomes visible to the FSM on the next cycle, not the same cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 at each bit boundary. Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: uart_out=1. If the FIFO is non-empty, pop into the shift register, go to START, and drive uart_out<=0 at that same edge.
  - START: hold 0 for one bit, then go to DATA with bit index 0.
  - DATA: drive shift[index], LSB first, for one bit each. After index 7, go to STOP (or PARITY, see Optional Feature).
  - STOP: hold 1 for one bit. At the end of the bit, if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- Latency: a byte accepted into an empty FIFO with the FSM in IDLE at edge E produces uart_out falling at edge E+1.
- Frame length: 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous, with frame period exactly 10*CLKS_PER_BIT.
- Registered output: uart_out is a register, glitch-free.
- busy: 1 whenever FSM!=IDLE or count!=0.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for one bit time.
  - Frame becomes 11*CLKS_PER_BIT cycles (8E1).
- Undefined: no PARITY state; 8N1 as above.

Test Plan (CLKS_PER_BIT=4, DEPTH=4):
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles, then release.
  - Response: uart_out=1, count=0, busy=0 and ready_out=0 during reset; ready_out=1 on the first cycle after release.
- Single byte:
  - Stimulus: push 0xA5 at edge E.
  - Response: uart_out falls at E+1. Line sequence, each bit 4 cycles: 0,1,0,1,0,0,1,0,1,1. After 40 cycles FSM is IDLE and busy=0.
- Full FIFO:
  - Stimulus: hold valid_in=1 with bytes 0x01..0x06 from IDLE.
  - Response:
    - 0x01 is popped into the shift register; 0x02..0x05 fill the FIFO.
    - count=4 and ready_out=0; 0x06 is not accepted while ready_out=0.
    - Frames 0x01..0x05 go out contiguously, 40 cycles apart, with no idle gap.
    - count decrements at each START.
- Simultaneous push/pop:
  - Stimulus: with count=2, push a byte at the edge where STOP ends.
  - Response: count stays 2; the next START begins on the same edge.
- Mid-frame reset:
  - Stimulus: rst_n=0 during DATA bit 3 of 0x00.
  - Response: uart_out=1 on the next edge and count=0; after release, no residual frame is sent.
- Parity (UART_TX_PARITY_EN defined):
  - Stimulus: send 0x07.
  - Response: a parity bit of 1 follows the data bits, then the stop bit; frame length 44 cycles.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte-producer handshake and serial-line bundle for uart_tx_fifo.
interface uart_tx_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    data_in;
    logic          valid_in;
    logic          ready_out;
    logic          uart_out;
    logic          busy;
    logic [CW-1:0] count;

    modport master (
        output data_in, valid_in,
        input  ready_out, uart_out, busy, count
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, uart_out, busy, count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter (8N1; 8E1 when UART_TX_PARITY_EN is defined).
// Synchronous active-low reset; uart_out, busy and count are registered.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH        = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    logic full_c;
    logic empty_c;
    logic push_c;
    logic pop_c;

    // Transmitter state
    state_t        state;
    state_t        state_d;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_idx;
    logic [2:0]    idx_d;
    logic [7:0]    shift;
    logic [7:0]    shift_d;
    logic          tx_q;
    logic          tx_d;
    logic          busy_q;
    logic          baud_end_c;

    assign full_c        = (cnt == CW'(DEPTH));
    assign empty_c       = (cnt == '0);
    assign bus.ready_out = rst_n && !full_c;
    assign push_c        = bus.valid_in && bus.ready_out;
    assign baud_end_c    = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    assign bus.uart_out  = tx_q;
    assign bus.busy      = busy_q;
    assign bus.count     = cnt;

    // Occupancy update; a full FIFO never pushes, so push+pop keeps count
    always_comb begin
        cnt_d = cnt;
        unique case ({push_c, pop_c})
            2'b10:   cnt_d = cnt + CW'(1);
            2'b01:   cnt_d = cnt - CW'(1);
            default: cnt_d = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt_d;
        end
    end

    // Transmitter register bank
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= idx_d;
            shift    <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= (state_d != IDLE) || (cnt_d != '0);
        end
    end

    // Next-state logic; tx_d is the line level for the cycle after this edge
    always_comb begin
        state_d = state;
        baud_d  = baud_end_c ? '0 : baud_cnt + BW'(1);
        idx_d   = bit_idx;
        shift_d = shift;
        tx_d    = tx_q;
        pop_c   = 1'b0;

        unique case (state)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = mem[rd_ptr];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_end_c) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = shift[0];
                end
            end
            DATA: begin
                tx_d = shift[bit_idx];
                if (baud_end_c) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^shift;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = bit_idx + 3'd1;
                        tx_d  = shift[bit_idx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = ^shift;
                if (baud_end_c) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (baud_end_c) begin
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end
endmodule
